mul_sched: RTL and testbench
============================

# mul_sched

Round-robin scheduler that shares one sequential shift-add multiplier engine among `NREQ` requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester at a time and runs the 32-iteration shift-add algorithm, one iteration per clock. It returns the truncated product with the requester's ID over a valid/ready response channel. It sits between the DPI-driven request sources and the multiplier datapath, replacing per-caller blocking task calls with a shared, arbitrated resource.

## Interface
Reset is asynchronous, active-low (`rst_n`). There is one clock (`clk`).

Parameters:
- `NREQ`, 4: number of requesters; must be ≥2.
- `WIDTH`, 32: operand and result width; also the iteration count.
- `IDW`, `$clog2(NREQ)`: requester ID width (derived).

Ports:
- `clk`, in, 1: clock; all state updates on posedge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, `NREQ`: per-requester request valid.
- `req_ready`, out, `NREQ`: per-requester accept; at most one bit high.
- `req_a`, in, `NREQ×WIDTH`: multiplicand per requester.
- `req_b`, in, `NREQ×WIDTH`: multiplier per requester.
- `rsp_valid`, out, 1: result available.
- `rsp_ready`, in, 1: consumer accepts result.
- `rsp_id`, out, `IDW`: index of the requester that owns the result.
- `rsp_result`, out, `WIDTH`: product mod 2^WIDTH.
- `busy`, out, 1: high in BUSY or DONE.

## Operation
- FSM states:
  - IDLE: `req_ready` is the one-hot grant. The grant goes to the first set `req_valid` bit, searching from `rr_ptr` upward and wrapping.
  - Accept: `req_valid[g] & req_ready[g]`. Latch a=`req_a[g]`, b=`req_b[g]`, acc=0, cnt=0, id=g. Set `rr_ptr`=(g+1) mod `NREQ`. Go to BUSY.
  - BUSY: each cycle, if `b[0]` then acc += a (mod 2^WIDTH); then a <<= 1, b >>= 1, cnt++. When cnt reaches `WIDTH-1` and that iteration completes, go to DONE.
  - DONE: `rsp_valid`=1. `rsp_result`=acc and `rsp_id`=id, both stable until `rsp_ready`. On `rsp_ready`, go to IDLE.
- Iteration count is always exactly `WIDTH`. There is no early exit on b==0.
- No requests are accepted in BUSY or DONE. `req_ready` is all-zero there.
- DONE→IDLE and a new accept never occur in the same cycle. Accept is possible at the earliest on the first cycle in IDLE.
- `req_valid` deasserting before grant is legal; that requester is simply skipped.
- `rr_ptr` changes only on accept, never when idle with no requests.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `busy`=0, acc/a/b/cnt=0.
- Reset asserted mid-operation aborts immediately; the in-flight result is discarded.
- `req_ready` is combinational from `req_valid` and `rr_ptr` in IDLE. It has no dependence on `rsp_ready`.
- Latency: accept at edge E0, iterations at edges E1..E`WIDTH`, `rsp_valid` high starting the cycle after edge E`WIDTH`.
- Minimum occupancy: `WIDTH`+2 cycles per transaction. That is accept, `WIDTH` iterations, DONE≥1 cycle, and one IDLE cycle.
- Backpressure: `rsp_valid` held with all response outputs frozen for any number of cycles until `rsp_ready`.
- Simultaneous requests: strict round-robin. A requester that stays valid is served within `NREQ` transactions.

## Structure
- Shared package `mul_sched_pkg` contains:
  - the `state_e` enum {IDLE, BUSY, DONE};
  - `localparam` default `WIDTH`;
  - a function `rr_pick(valid, ptr)` returning the one-hot grant.
- Sub-module `shift_add_engine` holds the a/b/acc/cnt registers and the per-iteration step. It has `start`, `done` and `result` ports.
- `mul_sched` holds the FSM, the arbiter and the response register.

## Test plan
- Single request, requester 1, a=3, b=5 → `rsp_id`=1, `rsp_result`=15, `rsp_valid` rises exactly 32 cycles after the accept edge.
- All four `req_valid` high with distinct operands, `rsp_ready` tied 1 → grant order 0,1,2,3, then 0 again if still valid. Each result is correct.
- a=0xFFFFFFFF, b=2 → 0xFFFFFFFE. a=0x10000, b=0x10000 → 0x00000000 (truncation).
- `rsp_ready` held low 10 cycles after `rsp_valid` → outputs stable, `req_ready` all zero throughout, the next grant appears the cycle after IDLE re-entry.
- `rst_n` pulsed low at iteration 15 → all outputs zero immediately. After release, a new request a=7, b=6 returns 42.
- `rr_ptr`=2 with only requesters 0 and 3 valid → requester 3 is granted first, then requester 0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// rtl/mul_sched_pkg.sv - shared types, defaults and round-robin pick helper for mul_sched
package mul_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 32;

   // Upper bound on requester count supported by rr_pick; callers pass the real count in n.
   localparam int MAX_REQ = 32;
   localparam int MAX_IDX = $clog2(MAX_REQ);

   // One-hot grant: first set valid bit at or above ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input int ptr,
                                                  input int n);
      logic [MAX_REQ-1:0] g;
      logic               found;
      int                 idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx[MAX_IDX-1:0]]) begin
               g[idx[MAX_IDX-1:0]] = 1'b1;
               found               = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/mul_sched_shift_add_engine.sv
// rtl/mul_sched_shift_add_engine.sv - sequential shift-add multiplier, one iteration per clock
module shift_add_engine #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             run;

   // done marks the cycle whose iteration is the last one; the product is in acc after that edge.
   assign done   = run && (cnt == CW'(WIDTH - 1));
   assign result = acc;

   // Load operands on start, then step exactly WIDTH times; acc holds its value once stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a   <= '0;
         b   <= '0;
         acc <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         a   <= a_in;
         b   <= b_in;
         acc <= '0;
         cnt <= '0;
         run <= 1'b1;
      end else if (run) begin
         if (b[0]) acc <= acc + a;
         a   <= a << 1;
         b   <= b >> 1;
         cnt <= cnt + CW'(1);
         if (done) run <= 1'b0;
      end
   end

endmodule

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - round-robin scheduler sharing one shift-add multiplier among NREQ requesters
module mul_sched
   import mul_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  busy
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_BUSY = BUSY;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]         state;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     id_q;
   logic [IDW-1:0]     grant_id;
   logic [IDW-1:0]     next_ptr;
   logic [NREQ-1:0]    grant;
   logic [MAX_REQ-1:0] valid_ext;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               accept;
   logic               eng_done;
   logic [WIDTH-1:0]   eng_result;

   // Round-robin grant from the live valids; encode it and select the granted operands.
   always_comb begin
      valid_ext               = '0;
      valid_ext[NREQ-1:0]     = req_valid;
      grant                   = NREQ'(rr_pick(valid_ext, int'(rr_ptr), NREQ));
      grant_id                = '0;
      op_a                    = '0;
      op_b                    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            grant_id = IDW'(i);
            op_a     = req_a[i*WIDTH +: WIDTH];
            op_b     = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign next_ptr   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
   assign req_ready  = (state == ST_IDLE) ? grant : '0;
   assign accept     = (state == ST_IDLE) && (|grant);
   assign busy       = (state != ST_IDLE);
   assign rsp_valid  = (state == ST_DONE);
   assign rsp_id     = rsp_valid ? id_q : '0;
   assign rsp_result = rsp_valid ? eng_result : '0;

   // Transaction FSM: accept in IDLE, wait out the engine, hold the response until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         rr_ptr <= '0;
         id_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state  <= ST_BUSY;
                  id_q   <= grant_id;
                  rr_ptr <= next_ptr;
               end
            end
            ST_BUSY: if (eng_done) state <= ST_DONE;
            ST_DONE: if (rsp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   shift_add_engine #(
      .WIDTH(WIDTH)
   ) u_engine (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept),
      .a_in   (op_a),
      .b_in   (op_b),
      .done   (eng_done),
      .result (eng_result)
   );

endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - self-checking bench for mul_sched
module tb_mul_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_result;
   logic                  busy;

   mul_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] res;
   } exp_t;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every response handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got id %0d result %h with nothing expected", rsp_id, rsp_result);
         end else begin
            mon_e = sb.pop_front();
            if (rsp_id !== IDW'(mon_e.id) || rsp_result !== mon_e.res) begin
               errors++;
               $display("FAIL rsp: got id %0d result %h expected id %0d result %h",
                        rsp_id, rsp_result, mon_e.id, mon_e.res);
            end
         end
      end
   end

   // No grant may be offered while the engine or the response is occupied.
   always @(negedge clk) begin
      if (rst_n && busy) begin
         checks++;
         if (req_ready !== '0) begin
            errors++;
            $display("FAIL ready_while_busy: got %b expected 0000", req_ready);
         end
      end
   end

   task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b);
      req_valid[id]            = 1'b1;
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
   endtask

   // Called just after a negedge; returns once the accept edge has passed.
   task automatic wait_accept(output int gid, output int t);
      int n;
      gid = -1;
      t   = 0;
      n   = 0;
      #1;
      while (((req_valid & req_ready) == '0) && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no grant expected a grant within 200 cycles");
      end else begin
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
         t = cyc;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      int g, t, n;
      exp_t e;
      @(negedge clk);
      drive(id, a, b);
      e.id  = id;
      e.res = exp;
      sb.push_back(e);
      wait_accept(g, t);
      req_valid[id] = 1'b0;
      chk("grant_single", 32'(g), 32'(id));
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n - 1), 32'(WIDTH));
      wait_drain();
   endtask

   vec_t vt[7];
   int   g, t, t0;
   int   order[5] = '{0, 1, 2, 3, 0};
   exp_t e;

   initial begin
      vt[0] = '{1, 32'h3,        32'h5,        32'hF};
      vt[1] = '{0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE};
      vt[2] = '{2, 32'h00010000, 32'h00010000, 32'h0};
      vt[3] = '{1, 32'h0,        32'd12345,    32'h0};
      vt[4] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
      vt[5] = '{2, 32'h80000000, 32'h3,        32'h80000000};
      vt[6] = '{3, 32'h12345678, 32'h10,       32'h23456780};

      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready",  32'(req_ready),  32'd0);
      chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
      chk("rst_rsp_id",     32'(rsp_id),     32'd0);
      chk("rst_rsp_result", rsp_result,      32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      rst_n = 1'b1;

      // Single-request vectors; the last one leaves the pointer back at 0.
      for (int i = 0; i < 7; i++) run_one(vt[i].id, vt[i].a, vt[i].b, vt[i].exp);

      // All four requesters valid together: strict rotation, requester 0 served again.
      @(negedge clk);
      drive(0, 32'd11, 32'd13);
      drive(1, 32'h0000FFFF, 32'h0000FFFF);
      drive(2, 32'hDEADBEEF, 32'h1);
      drive(3, 32'h01000000, 32'h100);
      e = '{0, 32'd143};      sb.push_back(e);
      e = '{1, 32'hFFFE0001}; sb.push_back(e);
      e = '{2, 32'hDEADBEEF}; sb.push_back(e);
      e = '{3, 32'h0};        sb.push_back(e);
      e = '{0, 32'd143};      sb.push_back(e);
      for (int k = 0; k < 5; k++) begin
         wait_accept(g, t);
         chk("rr_order", 32'(g), 32'(order[k]));
         if (k == 0) t0 = t;
         if (k == 1) chk("occupancy", 32'(t - t0), 32'(WIDTH + 2));
      end
      req_valid = '0;
      wait_drain();

      // Backpressure: response frozen for 10 cycles while another requester waits.
      @(negedge clk);
      rsp_ready = 1'b0;
      drive(2, 32'd1000, 32'd1000);
      e = '{2, 32'h000F4240}; sb.push_back(e);
      wait_accept(g, t);
      req_valid[2] = 1'b0;
      chk("bp_grant", 32'(g), 32'd2);
      t = 0;
      while (!rsp_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      drive(0, 32'd9, 32'd9);
      e = '{0, 32'd81}; sb.push_back(e);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_valid",  32'(rsp_valid), 32'd1);
         chk("bp_id",     32'(rsp_id),    32'd2);
         chk("bp_result", rsp_result,     32'h000F4240);
         chk("bp_ready",  32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #2 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("regrant_after_idle", 32'(req_ready), 32'b0001);
      wait_accept(g, t);
      req_valid[0] = 1'b0;
      chk("bp_next_grant", 32'(g), 32'd0);
      wait_drain();

      // Reset mid-iteration discards the in-flight result.
      @(negedge clk);
      drive(1, 32'd5, 32'd9);
      wait_accept(g, t);
      req_valid[1] = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy",      32'(busy),      32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_rsp_id",    32'(rsp_id),    32'd0);
      chk("abort_result",    rsp_result,     32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_one(2, 32'd7, 32'd6, 32'd42);

      // Pointer at 2 with only requesters 0 and 3 valid: 3 wins, then 0.
      run_one(1, 32'd2, 32'd2, 32'd4);
      @(negedge clk);
      drive(0, 32'd6, 32'd7);
      drive(3, 32'h100, 32'h100);
      e = '{3, 32'h00010000}; sb.push_back(e);
      e = '{0, 32'd42};       sb.push_back(e);
      #1;
      chk("wrap_ready", 32'(req_ready), 32'b1000);
      wait_accept(g, t);
      req_valid[3] = 1'b0;
      chk("wrap_first", 32'(g), 32'd3);
      @(negedge clk);
      wait_accept(g, t);
      req_valid[0] = 1'b0;
      chk("wrap_second", 32'(g), 32'd0);
      wait_drain();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
